// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared widths, queue depth and FSM encoding for the fetch unit
package fetch_unit_pkg;
  localparam int DEF_BITS = 16;
  localparam int DEF_ADDRESS_BITS = 8;
  localparam int QUEUE_DEPTH = 3;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/fetch_unit_queue.sv
// fetch_queue: 3-entry in-order shift queue; entry 0 is the registered head
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int W = DEF_BITS + DEF_ADDRESS_BITS
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic [1:0]   count_o
);
  logic [W-1:0] mem_q [QUEUE_DEPTH];
  logic [W-1:0] mem_d [QUEUE_DEPTH];
  logic [1:0]   count_q, count_d, base;
  // shift toward the head on pop; a push lands just past the surviving entries
  always_comb begin
    base = count_q - 2'(pop_i);
    for (int i = 0; i < QUEUE_DEPTH; i++)
      mem_d[i] = (push_i && base == 2'(i)) ? data_i : pop_i ? mem_q[(i + 1) % QUEUE_DEPTH] : mem_q[i];
    count_d = flush_i ? 2'd0 : count_q + 2'(push_i) - 2'(pop_i);
  end
  // storage and occupancy registers
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) mem_q[i] <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < QUEUE_DEPTH; i++) mem_q[i] <= mem_d[i];
      count_q <= count_d;
    end
  assign data_o  = mem_q[0];
  assign valid_o = count_q != 2'd0;
  assign count_o = count_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: credit-limited instruction fetcher with branch redirect and 3-entry queue
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int BITS         = DEF_BITS,
  parameter int ADDRESS_BITS = DEF_ADDRESS_BITS,
  parameter int RESET_VECTOR = 0
) (
  input  logic                    CLK,
  input  logic                    RSTb,
  input  logic                    ENABLE,
  output logic [ADDRESS_BITS-1:0] MEM_ADDRESS,
  input  logic [BITS-1:0]         MEM_DATA,
  input  logic                    BRANCH_VALID,
  input  logic [ADDRESS_BITS-1:0] BRANCH_TARGET,
  output logic [BITS-1:0]         INSTR,
  output logic [ADDRESS_BITS-1:0] INSTR_PC,
  output logic                    INSTR_VALID,
  input  logic                    INSTR_READY
);
  state_t                  state_q;
  logic [ADDRESS_BITS-1:0] pc_q, pc_d, tag_q;
  logic                    inflight_q, issue, push, pop;
  logic [1:0]              count;
  // credit check uses only registered occupancy; a branch suppresses issue, push and pop
  always_comb begin
    issue = state_q == RUN && !BRANCH_VALID && ({1'b0, count} + {2'b0, inflight_q}) < 3'(QUEUE_DEPTH);
    pc_d  = BRANCH_VALID ? BRANCH_TARGET : issue ? pc_q + 1'b1 : pc_q;
    push  = inflight_q && !BRANCH_VALID;
    pop   = INSTR_VALID && INSTR_READY && !BRANCH_VALID;
  end
  // IDLE/RUN FSM plus PC and in-flight tracking
  always_ff @(posedge CLK or negedge RSTb)
    if (!RSTb) begin
      state_q    <= IDLE;
      pc_q       <= ADDRESS_BITS'(RESET_VECTOR);
      tag_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= ENABLE ? RUN : IDLE;
      pc_q       <= pc_d;
      tag_q      <= issue ? pc_q : tag_q;
      inflight_q <= issue;
    end
  fetch_queue #(.W(BITS + ADDRESS_BITS)) u_queue (
    .clk_i   (CLK),
    .rst_ni  (RSTb),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (BRANCH_VALID),
    .data_i  ({MEM_DATA, tag_q}),
    .data_o  ({INSTR, INSTR_PC}),
    .valid_o (INSTR_VALID),
    .count_o (count)
  );
  assign MEM_ADDRESS = pc_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of startup latency, stall, branch, wrap, disable and reset
module tb_fetch_unit;
  logic        CLK = 0, RSTb = 0, ENABLE = 0, BRANCH_VALID = 0, INSTR_READY = 0;
  logic [7:0]  MEM_ADDRESS, INSTR_PC, BRANCH_TARGET = 0;
  logic [15:0] MEM_DATA = 0, INSTR;
  logic        INSTR_VALID;
  int n_chk = 0, n_fail = 0;

  always #5 CLK = ~CLK;

  fetch_unit dut (
    .CLK(CLK), .RSTb(RSTb), .ENABLE(ENABLE), .MEM_ADDRESS(MEM_ADDRESS), .MEM_DATA(MEM_DATA),
    .BRANCH_VALID(BRANCH_VALID), .BRANCH_TARGET(BRANCH_TARGET), .INSTR(INSTR),
    .INSTR_PC(INSTR_PC), .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY)
  );

  function automatic logic [15:0] mv(input logic [7:0] a);
    return a == 8'h00 ? 16'h1004 : a == 8'h01 ? 16'h4e0a : {a, ~a};
  endfunction

  always @(posedge CLK) MEM_DATA <= mv(MEM_ADDRESS);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_stream(input logic [7:0] start, input int n);
    for (int k = 0; k < n; k++) begin
      logic [7:0] p;
      p = start + 8'(k);
      check("stream_valid", 32'(INSTR_VALID), 32'd1);
      check("stream_pc", 32'(INSTR_PC), 32'(p));
      check("stream_instr", 32'(INSTR), 32'(mv(p)));
      @(negedge CLK);
    end
  endtask

  task automatic startup(input logic rdy);
    @(negedge CLK);
    RSTb = 1; ENABLE = 1; INSTR_READY = rdy;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      check("startup_not_valid", 32'(INSTR_VALID), 32'd0);
    end
    @(negedge CLK);
  endtask

  task automatic branch(input logic [7:0] t);
    BRANCH_VALID = 1; BRANCH_TARGET = t; INSTR_READY = 1;
    @(negedge CLK);
    BRANCH_VALID = 0;
    check("br_flush_valid", 32'(INSTR_VALID), 32'd0);
    check("br_target_addr", 32'(MEM_ADDRESS), 32'(t));
    @(negedge CLK);
    check("br_wait_valid", 32'(INSTR_VALID), 32'd0);
    @(negedge CLK);
  endtask

  initial begin
    ENABLE = 1; INSTR_READY = 1;
    #12;
    check("rst_valid", 32'(INSTR_VALID), 32'd0);
    check("rst_instr", 32'(INSTR), 32'd0);
    check("rst_pc", 32'(INSTR_PC), 32'd0);
    check("rst_addr", 32'(MEM_ADDRESS), 32'd0);
    startup(1);
    expect_stream(8'h00, 4);
    RSTb = 0;
    startup(0);
    repeat (10) @(negedge CLK);
    check("stall_addr", 32'(MEM_ADDRESS), 32'd3);
    check("stall_valid", 32'(INSTR_VALID), 32'd1);
    check("stall_pc", 32'(INSTR_PC), 32'd0);
    check("stall_instr", 32'(INSTR), 32'h1004);
    INSTR_READY = 1;
    expect_stream(8'h00, 10);
    RSTb = 0;
    startup(0);
    @(negedge CLK);
    check("pre_branch_addr", 32'(MEM_ADDRESS), 32'd3);
    branch(8'h20);
    expect_stream(8'h20, 3);
    branch(8'hFD);
    expect_stream(8'hFD, 5);
    ENABLE = 0; INSTR_READY = 0;
    repeat (4) @(negedge CLK);
    check("disable_addr", 32'(MEM_ADDRESS), 32'h05);
    check("disable_valid", 32'(INSTR_VALID), 32'd1);
    check("disable_pc", 32'(INSTR_PC), 32'h02);
    INSTR_READY = 1;
    expect_stream(8'h02, 2);
    #2 RSTb = 0;
    #1;
    check("midrst_valid", 32'(INSTR_VALID), 32'd0);
    check("midrst_instr", 32'(INSTR), 32'd0);
    check("midrst_pc", 32'(INSTR_PC), 32'd0);
    check("midrst_addr", 32'(MEM_ADDRESS), 32'd0);
    startup(1);
    expect_stream(8'h00, 2);
    ENABLE = 0;
    repeat (4) @(negedge CLK);
    check("idle_drained", 32'(INSTR_VALID), 32'd0);
    BRANCH_VALID = 1; BRANCH_TARGET = 8'h40;
    @(negedge CLK);
    BRANCH_VALID = 0;
    check("idle_br_addr", 32'(MEM_ADDRESS), 32'h40);
    repeat (2) @(negedge CLK);
    check("idle_hold_addr", 32'(MEM_ADDRESS), 32'h40);
    check("idle_no_valid", 32'(INSTR_VALID), 32'd0);
    ENABLE = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      check("idle_restart_wait", 32'(INSTR_VALID), 32'd0);
    end
    @(negedge CLK);
    expect_stream(8'h40, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
